// File: rtl/traffic_phase_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_phase_ctrl
//
// Purpose:
//   Phase controller for a highway / farm-road intersection. The highway
//   rests on green and yields to the farm road only after a minimum green
//   time has elapsed and at least one car is waiting in the farm-road queue.
//   The farm road then stays green until its queue is empty or a maximum
//   green time runs out. While the farm road is green, one car departs
//   every PASS_CYCLES cycles. Each departure is signalled to the queue stage
//   with a one-cycle dec_car_in_queue pulse.
//
// Parameters:
//   HWY_MIN_GREEN  minimum highway-green duration, traffic_clk cycles
//   FR_MAX_GREEN   maximum farm-road-green duration, cycles
//   YELLOW_CYCLES  duration of either yellow phase, cycles
//   PASS_CYCLES    cycles per departing farm-road car
//
// Ports:
//   traffic_clk        in   single clock, rising edge active
//   reset              in   asynchronous, active-low reset
//   car_queue_counter  in   [3:0] farm-road queue depth from the queue stage
//   emergency_req      in   emergency override request (optional build)
//   FarmRoad_Green     out  high while the farm-road light is green
//   dec_car_in_queue   out  one-cycle pulse: remove one car from the queue
//   hwy_light          out  [1:0] highway lamp: 00 red, 01 yellow, 10 green
//   fr_light           out  [1:0] farm-road lamp, same encoding
//   state_dbg          out  [1:0] current FSM state, for observation only
//
// Build option:
//   EMERGENCY_OVERRIDE_EN  When defined, this option adds the emergency_req
//                          input. While that input is high, the highway green
//                          phase holds and any farm-road green phase ends at
//                          the next edge. Yellow phases still run to
//                          completion.
//
// Handshake with the queue stage:
//   There is no valid/ready pair. dec_car_in_queue is a single-cycle command
//   that the queue stage must act on at the same rising edge. The pulse is
//   never raised while car_queue_counter reads zero, so the queue cannot
//   underflow.
// ---------------------------------------------------------------------------
module traffic_phase_ctrl #(
    parameter int HWY_MIN_GREEN = 8,
    parameter int FR_MAX_GREEN  = 10,
    parameter int YELLOW_CYCLES = 3,
    parameter int PASS_CYCLES   = 2
) (
    input  logic       traffic_clk,
    input  logic       reset,
    input  logic [3:0] car_queue_counter,
`ifdef EMERGENCY_OVERRIDE_EN
    input  logic       emergency_req,
`endif
    output logic       FarmRoad_Green,
    output logic       dec_car_in_queue,
    output logic [1:0] hwy_light,
    output logic [1:0] fr_light,
    output logic [1:0] state_dbg
);

    // Lamp encoding shared by both roads.
    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    // Terminal counts, pre-sized to the 8-bit timer and pass counter.
    localparam logic [7:0] HWY_GREEN_LAST = 8'(HWY_MIN_GREEN - 1);
    localparam logic [7:0] FR_GREEN_LAST  = 8'(FR_MAX_GREEN - 1);
    localparam logic [7:0] YELLOW_LAST    = 8'(YELLOW_CYCLES - 1);
    localparam logic [7:0] PASS_LAST      = 8'(PASS_CYCLES - 1);
    localparam logic [7:0] TIMER_SAT      = 8'hFF;

    typedef enum logic [1:0] {
        HWY_GREEN  = 2'd0,
        HWY_YELLOW = 2'd1,
        FR_GREEN   = 2'd2,
        FR_YELLOW  = 2'd3
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] timer;
    logic [7:0] pass_cnt;
    logic       queue_nonzero;
    logic       hwy_hold;
    logic       fr_abort;

    assign queue_nonzero = (car_queue_counter != 4'd0);

`ifdef EMERGENCY_OVERRIDE_EN
    // An emergency keeps cross traffic stopped. The highway stays green, and
    // a farm-road green phase is cut short through its normal yellow phase.
    assign hwy_hold = emergency_req;
    assign fr_abort = emergency_req;
`else
    assign hwy_hold = 1'b0;
    assign fr_abort = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register, phase timer and pass counter.
    // The timer and the pass counter restart at every state change.
    // Both therefore read 0 in the first cycle of each phase. The timer
    // only grows large while the highway idles on green, and it saturates
    // there instead of wrapping. A wrap would make the minimum-green test
    // look unmet again.
    // ------------------------------------------------------------------
    always_ff @(posedge traffic_clk or negedge reset) begin
        if (!reset) begin
            state    <= HWY_GREEN;
            timer    <= 8'd0;
            pass_cnt <= 8'd0;
        end else begin
            state <= next_state;

            if (next_state != state) begin
                timer <= 8'd0;
            end else if (timer != TIMER_SAT) begin
                timer <= timer + 8'd1;
            end

            if (next_state != state) begin
                pass_cnt <= 8'd0;
            end else if (state == FR_GREEN) begin
                if (pass_cnt == PASS_LAST) begin
                    pass_cnt <= 8'd0;
                end else begin
                    pass_cnt <= pass_cnt + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            HWY_GREEN: begin
                if (!hwy_hold && queue_nonzero && (timer >= HWY_GREEN_LAST)) begin
                    next_state = HWY_YELLOW;
                end
            end
            HWY_YELLOW: begin
                if (timer == YELLOW_LAST) begin
                    next_state = FR_GREEN;
                end
            end
            FR_GREEN: begin
                // An empty queue or the maximum green time ends the phase.
                // A departure pulse issued in the same cycle still goes out.
                if (fr_abort || !queue_nonzero || (timer == FR_GREEN_LAST)) begin
                    next_state = FR_YELLOW;
                end
            end
            FR_YELLOW: begin
                if (timer == YELLOW_LAST) begin
                    next_state = HWY_GREEN;
                end
            end
            default: begin
                next_state = HWY_GREEN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. The lamps and FarmRoad_Green come from the state register
    // only. The departure pulse is the one output that also looks at the
    // live queue depth, so that it can never decrement an empty queue.
    // ------------------------------------------------------------------
    always_comb begin
        hwy_light      = LAMP_GREEN;
        fr_light       = LAMP_RED;
        FarmRoad_Green = 1'b0;
        case (state)
            HWY_GREEN: begin
                hwy_light = LAMP_GREEN;
                fr_light  = LAMP_RED;
            end
            HWY_YELLOW: begin
                hwy_light = LAMP_YELLOW;
                fr_light  = LAMP_RED;
            end
            FR_GREEN: begin
                hwy_light      = LAMP_RED;
                fr_light       = LAMP_GREEN;
                FarmRoad_Green = 1'b1;
            end
            FR_YELLOW: begin
                hwy_light = LAMP_RED;
                fr_light  = LAMP_YELLOW;
            end
            default: begin
                hwy_light = LAMP_GREEN;
                fr_light  = LAMP_RED;
            end
        endcase
    end

    assign dec_car_in_queue = (state == FR_GREEN) && (pass_cnt == PASS_LAST) && queue_nonzero;

    assign state_dbg = state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_ctrl
//
// Purpose:
//   Self-checking bench for traffic_phase_ctrl with the default parameters.
//
// Table layout:
//   Each row of the table is one segment. A segment may first apply a reset
//   or load a new queue depth. It then lasts n cycles, and each of those
//   cycles has the same expected lamp pair.
//
// Departure pulses:
//   Inside a farm-road green segment, dec is expected on every second cycle,
//   starting with the second one.
//
// Queue-stage model:
//   The bench can act as the queue stage. In that mode it decrements its
//   queue depth at each edge where the DUT pulsed dec_car_in_queue.
//
// Optional build:
//   The emergency-override case is compiled in when EMERGENCY_OVERRIDE_EN
//   is defined.
// ---------------------------------------------------------------------------
module tb_traffic_phase_ctrl;

    localparam logic [1:0] L_RED = 2'b00;
    localparam logic [1:0] L_YEL = 2'b01;
    localparam logic [1:0] L_GRN = 2'b10;

    // ---------------- clock / reset / DUT ----------------
    logic       traffic_clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] car_queue_counter = 4'd0;
`ifdef EMERGENCY_OVERRIDE_EN
    logic       emergency_req = 1'b0;
`endif
    logic       FarmRoad_Green;
    logic       dec_car_in_queue;
    logic [1:0] hwy_light;
    logic [1:0] fr_light;
    logic [1:0] state_dbg;

    always #5 traffic_clk = ~traffic_clk;

    traffic_phase_ctrl #(
        .HWY_MIN_GREEN(8),
        .FR_MAX_GREEN (10),
        .YELLOW_CYCLES(3),
        .PASS_CYCLES  (2)
    ) dut (
        .traffic_clk      (traffic_clk),
        .reset            (reset),
        .car_queue_counter(car_queue_counter),
`ifdef EMERGENCY_OVERRIDE_EN
        .emergency_req    (emergency_req),
`endif
        .FarmRoad_Green   (FarmRoad_Green),
        .dec_car_in_queue (dec_car_in_queue),
        .hwy_light        (hwy_light),
        .fr_light         (fr_light),
        .state_dbg        (state_dbg)
    );

    // ---------------- scoreboard ----------------
    // Expected word layout: {hwy[1:0], fr[1:0], FarmRoad_Green, dec}.
    logic [5:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    bit         auto_dec = 1'b0;

    typedef struct {
        string      name;
        bit         do_reset;
        bit         set_q;
        logic [3:0] q;
        bit         auto;
        int         n;
        logic [1:0] hwy;
        logic [1:0] fr;
        bit         dec_alt;
    } seg_t;

    seg_t segs[$];

    function automatic logic [5:0] pack_exp(logic [1:0] hwy, logic [1:0] fr, logic dec);
        return {hwy, fr, (fr == L_GRN), dec};
    endfunction

    function automatic logic [5:0] dut_word();
        return {hwy_light, fr_light, FarmRoad_Green, dec_car_in_queue};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp_w);
        n_checks++;
        if (act === exp_w) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got hwy=%b fr=%b frg=%b dec=%b, expected hwy=%b fr=%b frg=%b dec=%b",
                     name, cyc, act[5:4], act[3:2], act[1], act[0],
                     exp_w[5:4], exp_w[3:2], exp_w[1], exp_w[0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle. The task pushes the expected word and samples at the
    // falling edge. It then moves past the rising edge, and there it applies
    // any queue decrement that the sampled dec pulse asked for.
    task automatic run_cycle(input string name, input logic [1:0] hwy, input logic [1:0] fr,
                             input logic dec);
        logic [5:0] e;
        logic       dec_seen;
        exp_q.push_back(pack_exp(hwy, fr, dec));
        @(negedge traffic_clk);
        e = exp_q.pop_front();
        check(name, dut_word(), e);
        dec_seen = dec_car_in_queue;
        @(posedge traffic_clk);
        #1;
        if (auto_dec && dec_seen && (car_queue_counter != 4'd0)) begin
            car_queue_counter = car_queue_counter - 4'd1;
        end
        cyc++;
    endtask

    task automatic run_seg(input string name, input int n, input logic [1:0] hwy,
                           input logic [1:0] fr, input bit dec_alt);
        for (int i = 0; i < n; i++) begin
            run_cycle(name, hwy, fr, dec_alt && (i % 2 == 1));
        end
    endtask

    // Asserts reset between edges and checks that the outputs change
    // straight away. It holds reset across two edges, then releases it
    // just after a rising edge. The next sample is therefore cycle 0 of
    // HWY_GREEN.
    task automatic do_reset(input logic [3:0] q, input bit auto);
        @(posedge traffic_clk);
        #1;
        reset = 1'b0;
        car_queue_counter = q;
        auto_dec = auto;
        #1;
        check("reset_async", dut_word(), pack_exp(L_GRN, L_RED, 1'b0));
        repeat (2) @(posedge traffic_clk);
        @(negedge traffic_clk);
        check("reset_hold", dut_word(), pack_exp(L_GRN, L_RED, 1'b0));
        @(posedge traffic_clk);
        #1;
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic add_seg(input string name, input bit do_rst, input bit set_q, input logic [3:0] q,
                           input bit auto, input int n, input logic [1:0] hwy, input logic [1:0] fr,
                           input bit dec_alt);
        seg_t s;
        s.name = name; s.do_reset = do_rst; s.set_q = set_q; s.q = q; s.auto = auto;
        s.n = n; s.hwy = hwy; s.fr = fr; s.dec_alt = dec_alt;
        segs.push_back(s);
    endtask

    // ---------------- test ----------------
    initial begin
        // The expected timeline uses the default parameters:
        // HWY_MIN_GREEN=8, YELLOW_CYCLES=3, FR_MAX_GREEN=10, PASS_CYCLES=2.

        // Scenario 1: the queue stays empty, so the highway stays green.
        add_seg("s1_idle",     1, 1, 4'd0,  0, 50, L_GRN, L_RED, 0);

        // Scenario 2: queue of 3, and the bench drains it on each pulse.
        // The farm road sees pulses on its green cycles 2, 4 and 6. It reads
        // an empty queue on cycle 7.
        add_seg("s2_hg",       1, 1, 4'd3,  1, 8,  L_GRN, L_RED, 0);
        add_seg("s2_hy",       0, 0, 4'd0,  0, 3,  L_YEL, L_RED, 0);
        add_seg("s2_fg",       0, 0, 4'd0,  0, 7,  L_RED, L_GRN, 1);
        add_seg("s2_fy",       0, 0, 4'd0,  0, 3,  L_RED, L_YEL, 0);
        add_seg("s2_hg_rest",  0, 0, 4'd0,  0, 12, L_GRN, L_RED, 0);

        // Scenario 3: queue held at 15. The farm road times out after 10
        // cycles with 5 pulses. The last pulse coincides with the timeout.
        add_seg("s3_hg",       1, 1, 4'hF,  0, 8,  L_GRN, L_RED, 0);
        add_seg("s3_hy",       0, 0, 4'd0,  0, 3,  L_YEL, L_RED, 0);
        add_seg("s3_fg",       0, 0, 4'd0,  0, 10, L_RED, L_GRN, 1);
        add_seg("s3_fy",       0, 0, 4'd0,  0, 3,  L_RED, L_YEL, 0);
        add_seg("s3_hg2",      0, 0, 4'd0,  0, 8,  L_GRN, L_RED, 0);
        add_seg("s3_hy2",      0, 0, 4'd0,  0, 2,  L_YEL, L_RED, 0);

        // Scenario 5: a car arrives at cycle 20 of highway green, and the
        // highway turns yellow at the next edge. That single car leaves on
        // farm-road cycle 2, and the phase ends on cycle 3.
        add_seg("s5_hg",       1, 1, 4'd0,  1, 20, L_GRN, L_RED, 0);
        add_seg("s5_arrive",   0, 1, 4'd1,  1, 1,  L_GRN, L_RED, 0);
        add_seg("s5_hy",       0, 0, 4'd0,  0, 3,  L_YEL, L_RED, 0);
        add_seg("s5_fg",       0, 0, 4'd0,  0, 3,  L_RED, L_GRN, 1);
        add_seg("s5_fy",       0, 0, 4'd0,  0, 3,  L_RED, L_YEL, 0);
        add_seg("s5_hg_rest",  0, 0, 4'd0,  0, 4,  L_GRN, L_RED, 0);

        foreach (segs[k]) begin
            if (segs[k].do_reset) begin
                do_reset(segs[k].q, segs[k].auto);
            end else if (segs[k].set_q) begin
                car_queue_counter = segs[k].q;
                auto_dec = segs[k].auto;
            end
            run_seg(segs[k].name, segs[k].n, segs[k].hwy, segs[k].fr, segs[k].dec_alt);
        end

        // Scenario 4: reset pulsed during farm-road green cycle 1.
        do_reset(4'd2, 1'b1);
        run_seg("s4_hg", 8, L_GRN, L_RED, 0);
        run_seg("s4_hy", 3, L_YEL, L_RED, 0);
        #2;
        check("s4_fg_cycle1", dut_word(), pack_exp(L_RED, L_GRN, 1'b0));
        reset = 1'b0;
        #1;
        check("s4_midphase_reset", dut_word(), pack_exp(L_GRN, L_RED, 1'b0));
        @(negedge traffic_clk);
        check("s4_reset_no_dec_a", dut_word(), pack_exp(L_GRN, L_RED, 1'b0));
        @(posedge traffic_clk);
        @(negedge traffic_clk);
        check("s4_reset_no_dec_b", dut_word(), pack_exp(L_GRN, L_RED, 1'b0));
        @(posedge traffic_clk);
        #1;
        reset = 1'b1;
        cyc = 0;
        // The queue still holds 2 cars. The full minimum green restarts,
        // and both cars then leave on farm-road cycles 2 and 4.
        run_seg("s4_hg_restart", 8, L_GRN, L_RED, 0);
        run_seg("s4_hy",         3, L_YEL, L_RED, 0);
        run_seg("s4_fg",         5, L_RED, L_GRN, 1);
        run_seg("s4_fy",         3, L_RED, L_YEL, 0);
        run_seg("s4_hg_rest",    3, L_GRN, L_RED, 0);

`ifdef EMERGENCY_OVERRIDE_EN
        // Scenario 6: an emergency is raised on farm-road green cycle 1 with
        // 5 cars queued. The farm road yields at once. The highway then
        // holds until the request drops, and after that the normal
        // sequence resumes.
        do_reset(4'd5, 1'b0);
        run_seg("s6_hg", 8, L_GRN, L_RED, 0);
        run_seg("s6_hy", 3, L_YEL, L_RED, 0);
        emergency_req = 1'b1;
        run_seg("s6_fg_abort", 1,  L_RED, L_GRN, 0);
        run_seg("s6_fy",       3,  L_RED, L_YEL, 0);
        run_seg("s6_hg_hold",  12, L_GRN, L_RED, 0);
        emergency_req = 1'b0;
        run_seg("s6_hg_release", 1,  L_GRN, L_RED, 0);
        run_seg("s6_hy2",        3,  L_YEL, L_RED, 0);
        run_seg("s6_fg2",        10, L_RED, L_GRN, 1);
        run_seg("s6_fy2",        1,  L_RED, L_YEL, 0);
`endif

        // ---------------- final report ----------------
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
